// File: rtl/alu_issue_ctrl.sv
// Issue stage in front of the 4-bit ALU: command FIFO, registered ALU drive,
// architectural carry/zero flags and in-flight tracking for carry-consuming ops.
module alu_issue_ctrl #(
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     cmd_valid,
  output logic                     cmd_ready,
  input  logic [3:0]               cmd_ctl,
  input  logic [3:0]               cmd_a,
  input  logic [3:0]               cmd_b,
  output logic                     alu_valid,
  output logic [3:0]               alu_ctl,
  output logic [3:0]               alu_a,
  output logic [3:0]               alu_b,
  output logic                     alu_cin,
  input  logic                     alu_valid_out,
  input  logic                     alu_carry,
  input  logic                     alu_zero,
  input  logic                     flag_clr,
  output logic                     carry_flag,
  output logic                     zero_flag,
  output logic [$clog2(DEPTH):0]   fifo_level,
  output logic [1:0]               outstanding,
  output logic [7:0]               drop_cnt
);

  localparam int PW = $clog2(DEPTH);
  localparam logic [PW:0] LVL_FULL = (PW+1)'(DEPTH);
  localparam logic [PW:0] LVL_ZERO = (PW+1)'(0);
  localparam logic [PW:0] LVL_ONE  = (PW+1)'(1);
  localparam logic [PW-1:0] PTR_ONE = PW'(1);

  logic [11:0]   r_mem [DEPTH];
  logic [PW-1:0] r_wr_ptr;
  logic [PW-1:0] r_rd_ptr;
  logic [PW:0]   r_level;
  logic [1:0]    r_outstanding;
  logic [7:0]    r_drop_cnt;
  logic          r_carry_flag;
  logic          r_zero_flag;
  logic          r_alu_valid;
  logic [3:0]    r_alu_ctl;
  logic [3:0]    r_alu_a;
  logic [3:0]    r_alu_b;
  logic          r_alu_cin;

  logic          w_ready;
  logic          w_push;
  logic          w_empty;
  logic [11:0]   w_head;
  logic          w_head_invalid;
  logic          w_head_carry_op;
  logic          w_issue;
  logic          w_drop;
  logic          w_pop;

  assign w_ready = (r_level != LVL_FULL);
  assign w_push  = cmd_valid && w_ready;
  assign w_empty = (r_level == LVL_ZERO);
  assign w_head  = r_mem[r_rd_ptr];

  // Carry-consuming ops wait for every older result so alu_cin sees the final flag.
  always_comb begin
    w_head_invalid  = 1'b0;
    w_head_carry_op = 1'b0;
    w_issue         = 1'b0;
    w_drop          = 1'b0;
    case (w_head[11:8])
      4'd14, 4'd15: w_head_invalid  = 1'b1;
      4'd4, 4'd6:   w_head_carry_op = 1'b1;
      default:      w_head_invalid  = 1'b0;
    endcase
    if (w_empty) begin
      w_issue = 1'b0;
      w_drop  = 1'b0;
    end else if (w_head_invalid) begin
      w_drop = 1'b1;
    end else if (w_head_carry_op) begin
      w_issue = (r_outstanding == 2'd0);
    end else begin
      w_issue = (r_outstanding != 2'd3);
    end
    w_pop = w_issue || w_drop;
  end

  // Payload storage needs no reset; occupancy is tracked by the pointers and level.
  always_ff @(posedge clk) begin
    if (w_push) begin
      r_mem[r_wr_ptr] <= {cmd_ctl, cmd_a, cmd_b};
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_level  <= LVL_ZERO;
    end else begin
      if (w_push) begin
        r_wr_ptr <= r_wr_ptr + PTR_ONE;
      end
      if (w_pop) begin
        r_rd_ptr <= r_rd_ptr + PTR_ONE;
      end
      case ({w_push, w_pop})
        2'b10:   r_level <= r_level + LVL_ONE;
        2'b01:   r_level <= r_level - LVL_ONE;
        default: r_level <= r_level;
      endcase
    end
  end

  // A return with nothing outstanding (stale, from before a reset) must not underflow.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_outstanding <= 2'd0;
    end else begin
      case ({w_issue, alu_valid_out})
        2'b10:   r_outstanding <= r_outstanding + 2'd1;
        2'b01:   r_outstanding <= (r_outstanding == 2'd0) ? 2'd0 : r_outstanding - 2'd1;
        default: r_outstanding <= r_outstanding;
      endcase
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_drop_cnt <= 8'd0;
    end else if (w_drop && (r_drop_cnt != 8'hFF)) begin
      r_drop_cnt <= r_drop_cnt + 8'd1;
    end else begin
      r_drop_cnt <= r_drop_cnt;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_carry_flag <= 1'b0;
      r_zero_flag  <= 1'b0;
    end else if (flag_clr) begin
      r_carry_flag <= 1'b0;
      r_zero_flag  <= 1'b0;
    end else if (alu_valid_out) begin
      r_carry_flag <= alu_carry;
      r_zero_flag  <= alu_zero;
    end else begin
      r_carry_flag <= r_carry_flag;
      r_zero_flag  <= r_zero_flag;
    end
  end

  // Operand/control registers hold between issues; only valid drops.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_alu_valid <= 1'b0;
      r_alu_ctl   <= 4'd0;
      r_alu_a     <= 4'd0;
      r_alu_b     <= 4'd0;
      r_alu_cin   <= 1'b0;
    end else if (w_issue) begin
      r_alu_valid <= 1'b1;
      r_alu_ctl   <= w_head[11:8];
      r_alu_a     <= w_head[7:4];
      r_alu_b     <= w_head[3:0];
      r_alu_cin   <= r_carry_flag;
    end else begin
      r_alu_valid <= 1'b0;
    end
  end

  assign cmd_ready   = w_ready;
  assign alu_valid   = r_alu_valid;
  assign alu_ctl     = r_alu_ctl;
  assign alu_a       = r_alu_a;
  assign alu_b       = r_alu_b;
  assign alu_cin     = r_alu_cin;
  assign carry_flag  = r_carry_flag;
  assign zero_flag   = r_zero_flag;
  assign fifo_level  = r_level;
  assign outstanding = r_outstanding;
  assign drop_cnt    = r_drop_cnt;

endmodule

// File: tb/tb_alu_issue_ctrl.sv
// Scoreboard bench for alu_issue_ctrl with a behavioural 1-cycle ALU whose
// returns can be held back to build up outstanding operations.
module tb_alu_issue_ctrl;

  typedef struct packed {
    logic [3:0] ctl;
    logic [3:0] a;
    logic [3:0] b;
    logic       cin;
  } iss_t;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       cmd_valid = 1'b0;
  logic       cmd_ready;
  logic [3:0] cmd_ctl = 4'd0;
  logic [3:0] cmd_a = 4'd0;
  logic [3:0] cmd_b = 4'd0;
  logic       alu_valid;
  logic [3:0] alu_ctl;
  logic [3:0] alu_a;
  logic [3:0] alu_b;
  logic       alu_cin;
  logic       alu_valid_out = 1'b0;
  logic       alu_carry = 1'b0;
  logic       alu_zero = 1'b0;
  logic       flag_clr = 1'b0;
  logic       carry_flag;
  logic       zero_flag;
  logic [2:0] fifo_level;
  logic [1:0] outstanding;
  logic [7:0] drop_cnt;

  int   n_checks = 0;
  int   n_errors = 0;
  int   cyc = 0;
  logic ret_en = 1'b1;
  iss_t exp_q[$];
  int   iss_cyc[$];
  logic [1:0] pend[$];
  iss_t mon_got;
  iss_t mon_exp;
  logic [1:0] mdl_res;

  alu_issue_ctrl #(.DEPTH(4)) dut (
    .clk(clk), .reset(reset), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_ctl(cmd_ctl), .cmd_a(cmd_a), .cmd_b(cmd_b),
    .alu_valid(alu_valid), .alu_ctl(alu_ctl), .alu_a(alu_a), .alu_b(alu_b), .alu_cin(alu_cin),
    .alu_valid_out(alu_valid_out), .alu_carry(alu_carry), .alu_zero(alu_zero),
    .flag_clr(flag_clr), .carry_flag(carry_flag), .zero_flag(zero_flag),
    .fifo_level(fifo_level), .outstanding(outstanding), .drop_cnt(drop_cnt)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // {carry, zero} of the reference ALU
  function automatic logic [1:0] alu_cz(input logic [3:0] c, input logic [3:0] a,
                                        input logic [3:0] b, input logic ci);
    logic [4:0] s;
    case (c)
      4'd0:    s = {1'b0, b};
      4'd1:    s = {1'b0, a} + 5'd1;
      4'd2:    s = {1'b0, a} - 5'd1;
      4'd3:    s = {1'b0, a} + {1'b0, b};
      4'd4:    s = {1'b0, a} + {1'b0, b} + {4'd0, ci};
      4'd5:    s = {1'b0, a} - {1'b0, b};
      4'd6:    s = {1'b0, a} - {1'b0, b} - {4'd0, ci};
      4'd7:    s = {1'b0, a & b};
      4'd8:    s = {1'b0, a | b};
      4'd9:    s = {1'b0, a ^ b};
      default: s = {1'b0, a};
    endcase
    return {s[4], (s[3:0] == 4'd0)};
  endfunction

  // Registered ALU model; returns are queued and released only while ret_en is high.
  always @(posedge clk) begin
    if (alu_valid) pend.push_back(alu_cz(alu_ctl, alu_a, alu_b, alu_cin));
    if (ret_en && pend.size() != 0) begin
      mdl_res = pend.pop_front();
      alu_valid_out <= 1'b1;
      alu_carry     <= mdl_res[1];
      alu_zero      <= mdl_res[0];
    end else begin
      alu_valid_out <= 1'b0;
    end
  end

  // Monitor: every alu_valid cycle is one issue and must match the scoreboard head.
  always @(negedge clk) begin
    if (!reset && alu_valid) begin
      mon_got = {alu_ctl, alu_a, alu_b, alu_cin};
      iss_cyc.push_back(cyc);
      if (exp_q.size() == 0) begin
        n_checks++;
        n_errors++;
        $display("FAIL unexpected_issue: got %h expected none", mon_got);
      end else begin
        mon_exp = exp_q.pop_front();
        chk("issue{ctl,a,b,cin}", 32'(mon_got), 32'(mon_exp));
      end
    end
  end

  task automatic push(input logic [3:0] c, input logic [3:0] a, input logic [3:0] b,
                      input logic exp_issue, input logic cin);
    int w = 0;
    @(negedge clk);
    while (!cmd_ready && w < 200) begin
      @(negedge clk);
      w++;
    end
    if (!cmd_ready) chk("push_ready_timeout", 32'(cmd_ready), 32'd1);
    cmd_valid = 1'b1;
    cmd_ctl = c;
    cmd_a = a;
    cmd_b = b;
    if (exp_issue) exp_q.push_back({c, a, b, cin});
    @(posedge clk);
  endtask

  task automatic push_end();
    @(negedge clk);
    cmd_valid = 1'b0;
  endtask

  task automatic wait_idle(input string name);
    int w = 0;
    do begin
      @(negedge clk);
      w++;
    end while (!(fifo_level == 3'd0 && outstanding == 2'd0 && !alu_valid && !alu_valid_out) && w < 300);
    if (w >= 300) chk({name, "_idle_timeout"}, 32'(fifo_level), 32'd0);
    chk({name, "_scoreboard_empty"}, 32'(exp_q.size()), 32'd0);
  endtask

  task automatic check_reset(input string tag);
    chk({tag, "_cmd_ready"}, 32'(cmd_ready), 32'd1);
    chk({tag, "_alu_valid"}, 32'(alu_valid), 32'd0);
    chk({tag, "_alu_ctl_a_b"}, 32'({alu_ctl, alu_a, alu_b}), 32'd0);
    chk({tag, "_alu_cin"}, 32'(alu_cin), 32'd0);
    chk({tag, "_flags"}, 32'({carry_flag, zero_flag}), 32'd0);
    chk({tag, "_fifo_level"}, 32'(fifo_level), 32'd0);
    chk({tag, "_outstanding"}, 32'(outstanding), 32'd0);
    chk({tag, "_drop_cnt"}, 32'(drop_cnt), 32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int w;
    repeat (3) @(negedge clk);
    check_reset("init");
    reset = 1'b0;

    // Throughput: three plain ops, consecutive alu_valid cycles
    iss_cyc.delete();
    push(4'd3, 4'h3, 4'h4, 1'b1, 1'b0);
    push(4'd9, 4'hF, 4'h5, 1'b1, 1'b0);
    push(4'd0, 4'h0, 4'h9, 1'b1, 1'b0);
    push_end();
    wait_idle("thru");
    chk("thru_issue_count", 32'(iss_cyc.size()), 32'd3);
    if (iss_cyc.size() == 3) begin
      chk("thru_gap01", 32'(iss_cyc[1] - iss_cyc[0]), 32'd1);
      chk("thru_gap12", 32'(iss_cyc[2] - iss_cyc[1]), 32'd1);
    end

    // Carry chain: F+1 sets carry, ADD_c must see cin=1 after two bubbles
    iss_cyc.delete();
    push(4'd3, 4'hF, 4'h1, 1'b1, 1'b0);
    push(4'd4, 4'h0, 4'h0, 1'b1, 1'b1);
    push_end();
    w = 0;
    while (!(alu_valid && alu_ctl == 4'd4) && w < 50) begin
      @(negedge clk);
      w++;
    end
    chk("carry_flag_at_addc_issue", 32'(carry_flag), 32'd1);
    wait_idle("carry");
    if (iss_cyc.size() == 2) chk("carry_gap", 32'(iss_cyc[1] - iss_cyc[0]), 32'd3);
    else chk("carry_issue_count", 32'(iss_cyc.size()), 32'd2);
    chk("carry_flag_after_addc", 32'(carry_flag), 32'd0);

    // Invalid opcodes are dropped and counted
    push(4'd14, 4'h1, 4'h2, 1'b0, 1'b0);
    push(4'd15, 4'h3, 4'h4, 1'b0, 1'b0);
    push(4'd3, 4'h2, 4'h3, 1'b1, 1'b0);
    push_end();
    wait_idle("invalid");
    chk("drop_cnt", 32'(drop_cnt), 32'd2);

    // Full FIFO with returns held back
    ret_en = 1'b0;
    push(4'd7, 4'hF, 4'h3, 1'b1, 1'b0);
    push(4'd8, 4'h1, 4'h2, 1'b1, 1'b0);
    push(4'd9, 4'h5, 4'h5, 1'b1, 1'b0);
    push(4'd3, 4'h1, 4'h1, 1'b1, 1'b0);
    push(4'd0, 4'h0, 4'h7, 1'b1, 1'b0);
    push(4'd7, 4'h6, 4'h3, 1'b1, 1'b0);
    push(4'd8, 4'h8, 4'h1, 1'b1, 1'b0);
    @(negedge clk);
    cmd_ctl = 4'd3;
    cmd_a = 4'hE;
    cmd_b = 4'hE;
    chk("full_cmd_ready", 32'(cmd_ready), 32'd0);
    chk("full_level", 32'(fifo_level), 32'd4);
    chk("full_outstanding", 32'(outstanding), 32'd3);
    repeat (3) @(negedge clk);
    chk("full_hold_level", 32'(fifo_level), 32'd4);
    cmd_valid = 1'b0;
    ret_en = 1'b1;
    wait_idle("full");

    // flag_clr coinciding with a carry-setting return
    push(4'd3, 4'hF, 4'h1, 1'b1, 1'b0);
    push_end();
    wait_idle("pre_clr");
    chk("pre_clr_carry", 32'(carry_flag), 32'd1);
    ret_en = 1'b0;
    push(4'd3, 4'hF, 4'hF, 1'b1, 1'b1);
    push_end();
    repeat (4) @(negedge clk);
    chk("clr_pending_outstanding", 32'(outstanding), 32'd1);
    ret_en = 1'b1;
    @(negedge clk);
    flag_clr = 1'b1;
    @(negedge clk);
    flag_clr = 1'b0;
    chk("clr_wins_flags", 32'({carry_flag, zero_flag}), 32'd0);
    chk("clr_outstanding", 32'(outstanding), 32'd0);

    // Reset mid-stream with three ops in flight and two queued
    ret_en = 1'b0;
    push(4'd9, 4'h1, 4'h1, 1'b1, 1'b0);
    push(4'd7, 4'h3, 4'h3, 1'b1, 1'b0);
    push(4'd3, 4'hF, 4'h1, 1'b1, 1'b0);
    push(4'd8, 4'h1, 4'h2, 1'b0, 1'b0);
    push(4'd0, 4'h0, 4'h5, 1'b0, 1'b0);
    push_end();
    w = 0;
    while (!(outstanding == 2'd3 && fifo_level == 3'd2) && w < 50) begin
      @(negedge clk);
      w++;
    end
    chk("mid_outstanding", 32'(outstanding), 32'd3);
    repeat (2) @(negedge clk);
    reset = 1'b1;
    exp_q.delete();
    #1;
    check_reset("mid");
    repeat (2) @(negedge clk);
    reset = 1'b0;
    chk("post_reset_cmd_ready", 32'(cmd_ready), 32'd1);
    ret_en = 1'b1;
    repeat (6) @(negedge clk);
    chk("stale_return_flags", 32'({carry_flag, zero_flag}), 32'd3);
    chk("stale_return_outstanding", 32'(outstanding), 32'd0);
    chk("end_scoreboard_empty", 32'(exp_q.size()), 32'd0);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
